// File: rtl/folded_bin_conv_engine.sv
// Binarised XNOR-popcount conv engine, CH_OUT/FOLD lanes stepped over FOLD cycles.
// Optional macro CONV_POP_PIPE_EN registers popcount ahead of the threshold compare.
module folded_bin_conv_engine #(
  parameter  int CH_IN       = 64,
  parameter  int K_S         = 3,
  parameter  int CH_OUT      = 64,
  parameter  int FOLD        = 2,
  localparam int POP_SIZE    = K_S*K_S*CH_IN,
  localparam int CH_OUT_FOLD = CH_OUT/FOLD,
  localparam int PW          = $clog2(POP_SIZE+1),
  localparam int FW          = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [POP_SIZE-1:0]             win_data,
  input  logic                            win_valid,
  output logic                            win_ready,
  output logic [CH_OUT-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic [FW-1:0]                   cfg_addr,
  input  logic [CH_OUT_FOLD*POP_SIZE-1:0] cfg_w,
  input  logic [CH_OUT_FOLD*PW-1:0]       cfg_th,
  input  logic [CH_OUT_FOLD-1:0]          cfg_pol,
  output logic                            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_HOLD
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [POP_SIZE-1:0]             r_win;
  logic [FW-1:0]                   r_fold;
  logic [CH_OUT-1:0]               r_res;
  logic [CH_OUT_FOLD*POP_SIZE-1:0] r_w   [FOLD];
  logic [CH_OUT_FOLD*PW-1:0]       r_th  [FOLD];
  logic [CH_OUT_FOLD-1:0]          r_pol [FOLD];

  logic                            w_last;
  logic                            w_cfg_ok;
  logic [CH_OUT_FOLD*PW-1:0]       w_pop;
  logic [CH_OUT_FOLD*PW-1:0]       w_cmp_pop;
  logic [FW-1:0]                   w_cmp_fold;
  logic                            w_cmp_en;
  logic                            w_done;
  logic                            w_step;
  logic [CH_OUT_FOLD-1:0]          w_bits;

  function automatic logic [PW-1:0] f_pop(input logic [POP_SIZE-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int b = 0; b < POP_SIZE; b++)
      s = s + PW'(v[b]);
    return s;
  endfunction

  assign w_last   = (r_fold == FW'(FOLD-1));
  assign w_cfg_ok = cfg_we && (r_state == S_IDLE)
                 && (32'(cfg_addr) < FOLD);

  // weight/threshold storage survives reset
  always_ff @(posedge clk) begin
    if (w_cfg_ok) begin
      r_w[cfg_addr]   <= cfg_w;
      r_th[cfg_addr]  <= cfg_th;
      r_pol[cfg_addr] <= cfg_pol;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CH_OUT_FOLD; i++)
      w_pop[i*PW +: PW] =
        f_pop(~(r_win ^ r_w[r_fold][i*POP_SIZE +: POP_SIZE]));
  end

`ifdef CONV_POP_PIPE_EN
  logic                      r_pvalid;
  logic                      r_drain;
  logic [FW-1:0]             r_pfold;
  logic [CH_OUT_FOLD*PW-1:0] r_pop;

  // extra COMPUTE cycle drains the last fold through the pipe
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pvalid <= 1'b0;
      r_drain  <= 1'b0;
      r_pfold  <= '0;
      r_pop    <= '0;
    end else begin
      r_pvalid <= (r_state == S_COMPUTE) && !r_drain;
      r_pfold  <= r_fold;
      r_pop    <= w_pop;
      if (r_state == S_COMPUTE)
        r_drain <= !r_drain && w_last;
      else
        r_drain <= 1'b0;
    end
  end

  assign w_cmp_en   = r_pvalid;
  assign w_cmp_fold = r_pfold;
  assign w_cmp_pop  = r_pop;
  assign w_done     = r_drain;
  assign w_step     = !r_drain;
`else
  assign w_cmp_en   = (r_state == S_COMPUTE);
  assign w_cmp_fold = r_fold;
  assign w_cmp_pop  = w_pop;
  assign w_done     = w_last;
  assign w_step     = 1'b1;
`endif

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < CH_OUT_FOLD; i++)
      w_bits[i] = (w_cmp_pop[i*PW +: PW] >
                   r_th[w_cmp_fold][i*PW +: PW])
                ^ r_pol[w_cmp_fold][i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fold  <= '0;
      r_res   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && win_valid) begin
        r_win  <= win_data;
        r_fold <= '0;
      end else if (r_state == S_COMPUTE && w_step) begin
        r_fold <= w_last ? '0 : r_fold + FW'(1);
      end
      if (w_cmp_en)
        for (int f = 0; f < FOLD; f++)
          if (w_cmp_fold == FW'(f))
            r_res[f*CH_OUT_FOLD +: CH_OUT_FOLD] <= w_bits;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (win_valid) w_next = S_COMPUTE;
      S_COMPUTE: if (w_done)    w_next = S_HOLD;
      S_HOLD:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    win_ready = reset && (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
    busy      = (r_state != S_IDLE);
  end

  assign out_data = r_res;

endmodule

// File: tb/tb_folded_bin_conv_engine.sv
// Scoreboard bench for folded_bin_conv_engine: FOLD=2/CH_OUT=4 and FOLD=3/CH_OUT=6.
// Works with or without CONV_POP_PIPE_EN (latency adjusts by one cycle).
`timescale 1ns/1ps
module tb_folded_bin_conv_engine;
  localparam int FA = 2;
  localparam int FB = 3;
`ifdef CONV_POP_PIPE_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam logic [17:0] ONES = 18'h3FFFF;
  localparam logic [17:0] NINE = 18'h001FF;

  typedef struct {
    logic [5:0] d;
    int         c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic a_pv   = 1'b0;
  logic b_pv   = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] a_win_data  = '0;
  logic        a_win_valid = 1'b0;
  logic        a_win_ready;
  logic [3:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic        a_cfg_we    = 1'b0;
  logic [0:0]  a_cfg_addr  = '0;
  logic [35:0] a_cfg_w     = '0;
  logic [9:0]  a_cfg_th    = '0;
  logic [1:0]  a_cfg_pol   = '0;
  logic        a_busy;

  logic [17:0] b_win_data  = '0;
  logic        b_win_valid = 1'b0;
  logic        b_win_ready;
  logic [5:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_cfg_we    = 1'b0;
  logic [1:0]  b_cfg_addr  = '0;
  logic [35:0] b_cfg_w     = '0;
  logic [9:0]  b_cfg_th    = '0;
  logic [1:0]  b_cfg_pol   = '0;
  logic        b_busy;

  folded_bin_conv_engine #(
    .CH_IN(2), .K_S(3), .CH_OUT(4), .FOLD(FA)
  ) u_a (
    .clk(clk), .reset(reset),
    .win_data(a_win_data), .win_valid(a_win_valid),
    .win_ready(a_win_ready),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr),
    .cfg_w(a_cfg_w), .cfg_th(a_cfg_th),
    .cfg_pol(a_cfg_pol), .busy(a_busy)
  );

  folded_bin_conv_engine #(
    .CH_IN(2), .K_S(3), .CH_OUT(6), .FOLD(FB)
  ) u_b (
    .clk(clk), .reset(reset),
    .win_data(b_win_data), .win_valid(b_win_valid),
    .win_ready(b_win_ready),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
    .cfg_w(b_cfg_w), .cfg_th(b_cfg_th),
    .cfg_pol(b_cfg_pol), .busy(b_busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitors: data and rise cycle on out_valid rise, stability while held
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (!a_pv) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_out", 32'(a_out_valid), 32'd0);
        end else begin
          ea = qa.pop_front();
          chk("a_data", 32'(a_out_data), 32'(ea.d[3:0]));
          chk("a_latency", 32'(cyc), 32'(ea.c));
        end
      end else begin
        chk("a_stable", 32'(a_out_data), 32'(ea.d[3:0]));
      end
    end
    a_pv <= a_out_valid;
  end

  always @(negedge clk) begin
    if (b_out_valid) begin
      if (!b_pv) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_out", 32'(b_out_valid), 32'd0);
        end else begin
          eb = qb.pop_front();
          chk("b_data", 32'(b_out_data), 32'(eb.d));
          chk("b_latency", 32'(cyc), 32'(eb.c));
        end
      end
    end
    b_pv <= b_out_valid;
  end

  task automatic cfg_a(input logic [0:0] ad, input logic [17:0] w,
                       input logic [4:0] th, input logic [1:0] pol);
    @(negedge clk);
    a_cfg_we = 1'b1; a_cfg_addr = ad;
    a_cfg_w = {w, w}; a_cfg_th = {th, th}; a_cfg_pol = pol;
    @(posedge clk); #1;
    a_cfg_we = 1'b0;
  endtask

  task automatic cfg_all_a(input logic [4:0] th, input logic [1:0] pol);
    cfg_a(1'b0, ONES, th, pol);
    cfg_a(1'b1, ONES, th, pol);
  endtask

  task automatic cfg_b(input logic [1:0] ad, input logic [4:0] th,
                       input logic [1:0] pol);
    @(negedge clk);
    b_cfg_we = 1'b1; b_cfg_addr = ad;
    b_cfg_w = {ONES, ONES}; b_cfg_th = {th, th}; b_cfg_pol = pol;
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
  endtask

  task automatic send_a(input logic [17:0] d, input logic [3:0] e,
                        input bit push);
    int n = 0;
    @(negedge clk);
    while (!a_win_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_win_ready) begin
      chk("a_accept_timeout", 32'(a_win_ready), 32'd1);
      return;
    end
    a_win_data = d; a_win_valid = 1'b1;
    @(posedge clk); #1;
    a_win_valid = 1'b0;
    if (push) qa.push_back('{d: 6'(e), c: cyc + FA + PX});
  endtask

  task automatic send_b(input logic [17:0] d, input logic [5:0] e);
    int n = 0;
    @(negedge clk);
    while (!b_win_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_win_ready) begin
      chk("b_accept_timeout", 32'(b_win_ready), 32'd1);
      return;
    end
    b_win_data = d; b_win_valid = 1'b1;
    @(posedge clk); #1;
    b_win_valid = 1'b0;
    qb.push_back('{d: e, c: cyc + FB + PX});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy)
           && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_win_ready", 32'(a_win_ready), 32'd0);
    chk("rst_b_win_ready", 32'(b_win_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_win_ready", 32'(a_win_ready), 32'd1);

    // all-ones weights, th=8: all-ones window -> all lanes set
    cfg_all_a(5'd8, 2'b00);
    send_a(ONES, 4'b1111, 1);
    wait_idle();
    // all-zeros window with slot 1 inverted
    cfg_a(1'b1, ONES, 5'd8, 2'b11);
    send_a('0, 4'b1100, 1);
    wait_idle();
    // threshold boundaries with pop = 9
    cfg_all_a(5'd9, 2'b00);
    send_a(NINE, 4'b0000, 1);
    wait_idle();
    cfg_all_a(5'd8, 2'b00);
    send_a(NINE, 4'b1111, 1);
    wait_idle();
    cfg_all_a(5'd31, 2'b11);
    send_a(NINE, 4'b1111, 1);
    wait_idle();
    cfg_all_a(5'd31, 2'b00);
    send_a(ONES, 4'b0000, 1);
    wait_idle();
    cfg_all_a(5'd18, 2'b00);
    send_a(ONES, 4'b0000, 1);
    wait_idle();

    // backpressure in HOLD
    cfg_all_a(5'd8, 2'b00);
    a_out_ready = 1'b0;
    send_a(ONES, 4'b1111, 1);
    begin
      int n = 0;
      @(negedge clk);
      while (!a_out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
      chk("bp_win_ready", 32'(a_win_ready), 32'd0);
      chk("bp_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_win_ready", 32'(a_win_ready), 32'd1);
    chk("bp_rel_busy", 32'(a_busy), 32'd0);
    chk("bp_rel_out_valid", 32'(a_out_valid), 32'd0);
    wait_idle();

    // cfg write while COMPUTE must be dropped
    send_a(ONES, 4'b1111, 1);
    a_cfg_we = 1'b1; a_cfg_addr = 1'b0;
    a_cfg_w = '0; a_cfg_th = '0; a_cfg_pol = '0;
    @(posedge clk); #1;
    a_cfg_we = 1'b0;
    wait_idle();
    send_a(ONES, 4'b1111, 1);
    wait_idle();

    // reset mid-window aborts it
    send_a(ONES, 4'b0000, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(a_out_valid), 32'd0);
    chk("abort_out_data", 32'(a_out_data), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_win_ready", 32'(a_win_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rel_win_ready", 32'(a_win_ready), 32'd1);
    send_a(ONES, 4'b1111, 1);
    wait_idle();

    // FOLD=3: distinct polarity per slot exposes fold order 0,1,2
    cfg_b(2'd0, 5'd8, 2'b00);
    cfg_b(2'd1, 5'd8, 2'b11);
    cfg_b(2'd2, 5'd8, 2'b10);
    send_b(ONES, 6'b010011);
    wait_idle();
    send_b('0, 6'b101100);
    wait_idle();
    send_b(ONES, 6'b010011);
    wait_idle();

    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/folded_bin_conv_engine.md
# folded_bin_conv_engine

Binarised convolution compute engine with an internal fold sequencer. One K_S×K_S×CH_IN binary window arrives over a valid/ready handshake, and the engine evaluates all CH_OUT output channels over FOLD cycles using CH_OUT/FOLD XNOR-popcount lanes. It thresholds each channel with per-channel polarity and presents the CH_OUT-bit result on a valid/ready output. It sits between the input line buffer and the max-pool stage, and generalises the fixed-fold conv layer: fold stepping is internal, flow control is full handshake, FOLD may be non-power-of-two, and thresholds support inversion.

## Interface
- CH_IN, 64, input channels
- K_S, 3, kernel side
- CH_OUT, 64, output channels
- FOLD, 2, time-multiplex factor; CH_OUT % FOLD == 0; any value ≥1
- POP_SIZE, K_S*K_S*CH_IN, derived; bits per window
- CH_OUT_FOLD, CH_OUT/FOLD, derived; parallel lanes
- PW, $clog2(POP_SIZE+1), derived; popcount/threshold width
- FW, (FOLD>1)?$clog2(FOLD):1, derived; fold index width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- win_data  in  POP_SIZE  window, bit index = (ky*K_S+kx)*CH_IN+c
- win_valid  in  1  window offered
- win_ready  out  1  engine accepts window
- out_data  out  CH_OUT  channel results, bit f*CH_OUT_FOLD+i = lane i of fold f
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  FW  fold slot to write
- cfg_w  in  CH_OUT_FOLD*POP_SIZE  lane i weights at [i*POP_SIZE +: POP_SIZE]
- cfg_th  in  CH_OUT_FOLD*PW  lane i threshold at [i*PW +: PW]
- cfg_pol  in  CH_OUT_FOLD  lane i polarity
- busy  out  1  high when not IDLE

## Operation
- Storage: FOLD-deep arrays for weights, thresholds and polarity, with combinational read at fold_cnt. They are not cleared by reset.
- cfg write: performed when cfg_we=1, state=IDLE and cfg_addr<FOLD. It is ignored otherwise, with no error flag.
- FSM states:
  - IDLE: win_ready=1. win_valid=1 latches win_data into win_reg, sets fold_cnt=0 and moves to COMPUTE.
  - COMPUTE: each cycle, lane i computes pop = popcount(~(win_reg ^ w[fold_cnt][i])).
    - bit = (pop > th[fold_cnt][i]) ^ pol[fold_cnt][i], written into res_reg[fold_cnt*CH_OUT_FOLD+i].
    - fold_cnt increments. When fold_cnt==FOLD-1, it wraps to 0 and the FSM moves to HOLD.
  - HOLD: out_valid=1, out_data=res_reg. out_ready=1 moves to IDLE.
- Compare is unsigned over PW bits. th ≥ POP_SIZE therefore forces the pre-polarity bit to 0, and th=0 with pop=0 yields 0.
- win_ready is 0 in COMPUTE and HOLD. No bypass from HOLD to a new window.
- res_reg is fully rewritten each window; out_data is stable throughout HOLD.

## Timing
- Reset (reset=0 at an edge) does the following:
  - state=IDLE, fold_cnt=0, res_reg=0, out_valid=0, busy=0.
  - win_ready is forced to 0 while reset is asserted and becomes 1 in the first cycle after release.
- Reset during COMPUTE or HOLD aborts the window, and the partial result is discarded.
- A window accepted at edge t is processed as follows:
  - fold f evaluates in cycle t+1+f.
  - out_valid rises after edge t+FOLD and is visible in cycle t+FOLD+1 (FOLD+1 cycle latency).
- With out_ready held at 1, the minimum window period is FOLD+2 cycles.
- A cfg write at edge t is visible to any window accepted at edge ≥ t+1.

## Configuration
- Macro CONV_POP_PIPE_EN.
- Defined: a register stage sits between popcount and compare, tagged with a delayed fold index.
  - COMPUTE lasts FOLD+1 cycles, with the last cycle draining the pipe.
  - Latency becomes FOLD+2 and the minimum period FOLD+3.
  - FSM states and handshake rules are unchanged.
- Undefined: popcount and compare are combinational within the COMPUTE cycle, with timing as above.

## Test plan
Parameters: CH_IN=2, K_S=3, CH_OUT=4, FOLD=2 (POP_SIZE=18, PW=5).
- Slots 0 and 1 loaded with w all-ones, th=8, pol=0; window all-ones accepted at edge t → out_valid in cycle t+3 with out_data=4'b1111 (pipe build: t+4).
- Same weights, window all-zeros, slot 1 pol=2'b11 → out_data=4'b1100.
- Threshold boundary: window with exactly 9 ones; th=9 → 4'b0000; th=8 → 4'b1111; th=31 with pol=1 → 4'b1111.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid=1, out_data unchanged, win_ready=0, busy=1. out_ready=1 → IDLE next cycle, win_ready=1.
- cfg_we=1 writing slot 0 with th=0 during COMPUTE → ignored; repeating test 1 still gives 4'b1111 at th=8.
- reset=0 in cycle t+2 of a window → out_valid=0 and res_reg=0 after that edge. After release win_ready=1 and a new window completes normally. Rerun with FOLD=3, CH_OUT=6: fold_cnt sequences 0,1,2,0.
